// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states,
// opcodes, ALU control codes, aluop/imm_src/select encodings and the
// per-state control word.
// Optional bne support is selected with the RV_MC_BNE_EN macro in the top.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        JAL      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // State-only part of the control outputs (Moore word).
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] aluop;
    } ctl_t;

    // Control word for a given state; anything not set stays zero.
    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.adr_src    = 1'b0;
                c.ir_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.aluop      = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.pc_update  = 1'b1;
            end
            DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_ADD;
            end
            MEMREAD: begin
                c.adr_src = 1'b1;
            end
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.aluop     = ALUOP_FUNCT;
            end
            EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.aluop     = ALUOP_FUNCT;
            end
            ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.aluop      = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.aluop      = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rv_alu_decoder.sv
// Combinational ALU decoder: aluop/funct3/funct7b5/op[5] -> 3-bit ALU control.
// Kept standalone so a pipelined core can reuse it unchanged.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // Only R-type (op5=1) with instr[30]=1 subtracts; addi never does.
    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_mc_control.sv
// Multicycle RV32I main controller. Steps each instruction through
// fetch/decode/execute and drives datapath selects, write strobes and the
// ALU control code. State-only outputs are registered alongside the state.
// Macro RV_MC_BNE_EN: when defined, funct3=001 in BEQ branches on ~zero (bne).
module rv_mc_control
    import rv_ctrl_pkg::*;
#(
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] dbg_state
);

    state_t state;
    state_t nxt;
    ctl_t   ctl;
    logic   known_op;
    logic   take;

    // Next-state selection; DECODE dispatches on the opcode.
    always_comb begin
        nxt = state;
        case (state)
            S_RST:    if (RESET_TO_FETCH || start) nxt = FETCH;
            FETCH:    nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_RTYPE:          nxt = EXECR;
                    OP_ITYPE:          nxt = EXECI;
                    OP_BRANCH:         nxt = BEQ;
                    OP_JAL:            nxt = JAL;
                    default:           nxt = FETCH;
                endcase
            end
            MEMADR:   nxt = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  nxt = MEMWB;
            MEMWB:    nxt = FETCH;
            MEMWRITE: nxt = FETCH;
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            ALUWB:    nxt = FETCH;
            BEQ:      nxt = FETCH;
            JAL:      nxt = ALUWB;
            default:  nxt = S_RST;
        endcase
    end

    // State register plus registered Moore control word; reset clears both
    // asynchronously so no write strobe outlives the asserting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= state_ctl(nxt);
        end
    end

    // Opcodes the controller knows how to sequence.
    always_comb begin
        known_op = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    end

    // Branch condition from funct3 and the live ALU zero flag.
    always_comb begin
        take = 1'b0;
        if (funct3 == 3'b000) begin
            take = zero;
        end
`ifdef RV_MC_BNE_EN
        else if (funct3 == 3'b001) begin
            take = ~zero;
        end
`endif
    end

    // Immediate format follows the opcode in every state except reset.
    always_comb begin
        imm_src = IMM_I;
        if (state != S_RST) begin
            case (op)
                OP_STORE:  imm_src = IMM_S;
                OP_BRANCH: imm_src = IMM_B;
                OP_JAL:    imm_src = IMM_J;
                default:   imm_src = IMM_I;
            endcase
        end
    end

    rv_alu_decoder u_alu_dec (
        .aluop       (ctl.aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (alu_control)
    );

    assign pc_write   = ctl.pc_update | (ctl.branch & take);
    assign adr_src    = ctl.adr_src;
    assign mem_write  = ctl.mem_write;
    assign ir_write   = ctl.ir_write;
    assign result_src = ctl.result_src;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign reg_write  = ctl.reg_write;
    assign illegal_op = (state == DECODE) & ~known_op;
    assign dbg_state  = state;

endmodule

// File: tb/tb_rv_mc_control.sv
// Directed bench for rv_mc_control. Each instruction pushes its hand-derived
// per-cycle output vectors into exp_q; the cycle loop pops and compares.
module tb_rv_mc_control;

    localparam int W = 21;

    // State encodings as seen on dbg_state
    localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3,
                   ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXECR = 7,
                   ST_EXECI = 8, ST_ALUWB = 9, ST_BEQ = 10, ST_JAL = 11;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] dbg_state;

    logic       pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, illegal_op0;
    logic [1:0] result_src0, alu_src_a0, alu_src_b0, imm_src0;
    logic [2:0] alu_control0;
    logic [3:0] dbg_state0;

    logic [W-1:0] obs, obs0;
    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    rv_mc_control #(.RESET_TO_FETCH(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .illegal_op(illegal_op),
        .dbg_state(dbg_state)
    );

    rv_mc_control #(.RESET_TO_FETCH(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write0), .adr_src(adr_src0),
        .mem_write(mem_write0), .ir_write(ir_write0), .result_src(result_src0),
        .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .imm_src(imm_src0),
        .reg_write(reg_write0), .alu_control(alu_control0), .illegal_op(illegal_op0),
        .dbg_state(dbg_state0)
    );

    assign obs  = {dbg_state, pc_write, adr_src, mem_write, ir_write, result_src,
                   alu_src_a, alu_src_b, imm_src, reg_write, alu_control, illegal_op};
    assign obs0 = {dbg_state0, pc_write0, adr_src0, mem_write0, ir_write0, result_src0,
                   alu_src_a0, alu_src_b0, imm_src0, reg_write0, alu_control0, illegal_op0};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pack one expected output vector, same field order as obs.
    function automatic logic [W-1:0] v(input int st, input int pcw, input int adr, input int mw,
                                       input int irw, input int rs, input int a, input int b,
                                       input int imm, input int rw, input int alu, input int ill);
        return {st[3:0], pcw[0], adr[0], mw[0], irw[0], rs[1:0], a[1:0], b[1:0],
                imm[1:0], rw[0], alu[2:0], ill[0]};
    endfunction

    task automatic push_fetch(input int imm);
        exp_q.push_back(v(ST_FETCH, 1, 0, 0, 1, 2, 0, 2, imm, 0, 0, 0));
    endtask

    task automatic push_decode(input int imm, input int ill);
        exp_q.push_back(v(ST_DECODE, 0, 0, 0, 0, 0, 1, 1, imm, 0, 0, ill));
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    // Advance one cycle per queued vector and compare.
    task automatic run(input string tag);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #2;
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    initial begin
        int bne_pcw;
`ifdef RV_MC_BNE_EN
        bne_pcw = 1;
`else
        bne_pcw = 0;
`endif
        rst_n = 1'b0;
        start = 1'b0;
        drive(7'b0, 3'b0, 1'b0, 1'b0);

        // Reset held 3 cycles: everything zero on both instances
        repeat (3) @(posedge clk);
        #2;
        check("rst", obs, '0);
        check("rst_start_mode", obs0, '0);
        rst_n = 1'b1;
        #1;
        check("rst_release", obs, '0);

        // add
        drive(7'b0110011, 3'b000, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_EXECR, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("add");
        check("hold_no_start", obs0, '0);

        // sub; start=1 lets the start-gated instance leave reset
        start = 1'b1;
        drive(7'b0110011, 3'b000, 1'b1, 1'b0);
        push_fetch(0);
        run("sub_fetch");
        check("start_to_fetch", obs0, v(ST_FETCH, 1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
        start = 1'b0;
        push_decode(0, 0);
        exp_q.push_back(v(ST_EXECR, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("sub");

        // lw: 5 states
        drive(7'b0000011, 3'b010, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_MEMADR, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        exp_q.push_back(v(ST_MEMREAD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(v(ST_MEMWB, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
        run("lw");

        // sw: imm_src=01 throughout, single mem_write cycle
        drive(7'b0100011, 3'b010, 1'b0, 1'b0);
        push_fetch(1); push_decode(1, 0);
        exp_q.push_back(v(ST_MEMADR, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        exp_q.push_back(v(ST_MEMWRITE, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        run("sw");

        // beq taken (mem_write must be gone in this FETCH)
        drive(7'b1100011, 3'b000, 1'b0, 1'b1);
        push_fetch(2); push_decode(2, 0);
        exp_q.push_back(v(ST_BEQ, 1, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        run("beq_taken");

        // beq not taken
        drive(7'b1100011, 3'b000, 1'b0, 1'b0);
        push_fetch(2); push_decode(2, 0);
        exp_q.push_back(v(ST_BEQ, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        run("beq_not_taken");

        // bne with zero=0: branches only when the bne option is built in
        drive(7'b1100011, 3'b001, 1'b0, 1'b0);
        push_fetch(2); push_decode(2, 0);
        exp_q.push_back(v(ST_BEQ, bne_pcw, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        run("bne");

        // blt-class funct3 never branches
        drive(7'b1100011, 3'b100, 1'b0, 1'b1);
        push_fetch(2); push_decode(2, 0);
        exp_q.push_back(v(ST_BEQ, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 0));
        run("branch_other_f3");

        // jal
        drive(7'b1101111, 3'b000, 1'b0, 1'b0);
        push_fetch(3); push_decode(3, 0);
        exp_q.push_back(v(ST_JAL, 1, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        run("jal");

        // I-type: ori, andi, slti, addi with instr[30]=1
        drive(7'b0010011, 3'b110, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_EXECI, 0, 0, 0, 0, 0, 2, 1, 0, 0, 3, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("ori");

        drive(7'b0010011, 3'b111, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_EXECI, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("andi");

        drive(7'b0010011, 3'b010, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_EXECI, 0, 0, 0, 0, 0, 2, 1, 0, 0, 5, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("slti");

        drive(7'b0010011, 3'b000, 1'b1, 1'b0);
        push_fetch(0); push_decode(0, 0);
        exp_q.push_back(v(ST_EXECI, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        exp_q.push_back(v(ST_ALUWB, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        run("addi_f7");

        // Unknown opcode: one-cycle illegal_op in DECODE, back to FETCH
        drive(7'b1111111, 3'b000, 1'b0, 1'b0);
        push_fetch(0); push_decode(0, 1); push_fetch(0);
        run("illegal");

        // sw again from FETCH, then reset dropped mid-MEMWRITE
        drive(7'b0100011, 3'b010, 1'b0, 1'b0);
        push_decode(1, 0);
        exp_q.push_back(v(ST_MEMADR, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        exp_q.push_back(v(ST_MEMWRITE, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        run("sw_pre_abort");
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        check("abort_async", obs, '0);
        repeat (2) @(posedge clk);
        #2;
        check("abort_hold", obs, '0);
        rst_n = 1'b1;

        // Restart after release
        push_fetch(1); push_decode(1, 0);
        exp_q.push_back(v(ST_MEMADR, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0));
        exp_q.push_back(v(ST_MEMWRITE, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        run("resume");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mc_control.md
Name: rv_mc_control

Overview:
- Multicycle RV32I main controller. Sits directly upstream of the ALU and drives its 3-bit ALU control code.
- Sequences each instruction through fetch, decode and execute states.
- Generates the datapath mux selects and write strobes.
- Consumes the ALU Zero flag to resolve branches.

Parameters:
- RESET_TO_FETCH, 1, 1: leave S_RST on the first clock after reset release; 0: hold S_RST until start=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; used only when RESET_TO_FETCH=0.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU Zero flag.
- pc_write  out  1  PC register enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction register / OldPC enable.
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- alu_src_a  out  2  00=PC, 01=OldPC, 10=RD1.
- alu_src_b  out  2  00=RD2, 01=ImmExt, 10=constant 4.
- imm_src  out  2  00=I, 01=S, 10=B, 11=J.
- reg_write  out  1  register file write enable.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.

Behaviour:
- Reset: rst_n=0 asynchronously forces state=S_RST.
  - In S_RST all outputs are 0.
  - First clock after release: go to FETCH (RESET_TO_FETCH=1), or stay until start=1.
  - rst_n asserted mid-instruction aborts immediately; no partial write strobe survives the asserting edge.
- Moore FSM. Every output is decoded from the state only, except:
  - pc_write = pc_update | (branch & zero), where zero is sampled combinationally.
  - alu_control, imm_src, illegal_op also depend on the decoded fields.
- Any select not listed for a state is 00.
- States and outputs:
  - FETCH: adr_src=0, ir_write=1, a=00, b=10, aluop=00, result_src=10, pc_update=1 -> DECODE.
  - DECODE: a=01, b=01, aluop=00. Next state by op:
    - 0000011/0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - else -> FETCH, with illegal_op=1 in DECODE.
  - MEMADR: a=10, b=01, aluop=00 -> MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1 -> MEMWB.
  - MEMWB: result_src=01, reg_write=1 -> FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 -> FETCH.
  - EXECR: a=10, b=00, aluop=10 -> ALUWB.
  - EXECI: a=10, b=01, aluop=10 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH.
  - BEQ: a=10, b=00, aluop=01, result_src=00, branch=1 -> FETCH.
  - JAL: a=01, b=10, aluop=00, result_src=00, pc_update=1 -> ALUWB.
- Latency in cycles: lw 5, sw 4, R/I 4, beq 3, jal 4.
- imm_src is decoded from op in every state: lw/I=00, sw=01, beq=10, jal=11, else 00.
- ALU decoder:
  - aluop 00 -> 000.
  - aluop 01 -> 001.
  - aluop 10 by funct3:
    - 000: 001 if (op[5] & funct7b5), else 000. addi with instr[30]=1 stays add.
    - 010 -> 101.
    - 110 -> 011.
    - 111 -> 010.
    - other -> 000.
- Branch condition: in BEQ, funct3 other than 000 (or 001 with the optional feature) never branches.

Optional Feature:
- Macro: RV_MC_BNE_EN.
- Defined: in BEQ, funct3=001 uses pc_write = pc_update | (branch & ~zero) (bne).
- Undefined: only funct3=000 can branch; bne falls through to PC+4.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum (S_RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL);
  - opcode localparams;
  - ALU control codes;
  - aluop and imm_src codes.
- Sub-module rv_alu_decoder: combinational aluop/funct3/funct7b5/op5 -> alu_control, shared with a future pipelined core.

Test Plan:
- Reset/start: hold rst_n=0 for 3 cycles -> all outputs 0; release -> FETCH next cycle with ir_write=1, pc_write=1, alu_control=000.
- add (op=0110011, funct3=000, funct7b5=0) -> states FETCH, DECODE, EXECR, ALUWB. In EXECR alu_control=000; in ALUWB reg_write=1. sub (funct7b5=1) gives 001 in EXECR.
- lw (op=0000011) -> 5 states. adr_src=1 in MEMREAD; MEMWB has result_src=01 and reg_write=1. sw (op=0100011) gives a mem_write pulse of exactly 1 cycle and imm_src=01.
- beq: zero=1 -> pc_write=1 in BEQ, alu_control=001. zero=0 -> pc_write=0. bne (funct3=001, zero=0): pc_write=1 only with RV_MC_BNE_EN.
- I-type: ori (funct3=110) -> 011; andi -> 010; slti -> 101; addi with funct7b5=1 -> 000.
- Edge cases: op=1111111 -> illegal_op pulse in DECODE, then FETCH. rst_n dropped during MEMWRITE -> mem_write=0 at once and S_RST holds until release.
